// File: rtl/mod_arith_pipe.sv
// Four-stage modular mul/add/sub/MAC unit over Z_Q with Barrett reduction.
// The whole pipe advances together and holds while the output is stalled.
module mod_arith_pipe #(
    parameter int WIDTH = 13,
    parameter int Q     = 7681,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             range_err,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int K  = 2 * WIDTH;
    localparam int PW = 2 * WIDTH;
    localparam int MW = WIDTH + 2;
    localparam int RW = WIDTH + 2;
    localparam logic [MW-1:0]    M  = MW'((64'd1 << K) / 64'(Q));
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [RW-1:0]    QR = RW'(Q);
    localparam logic [WIDTH:0]   QS = (WIDTH + 1)'(Q);

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    logic             adv;
    logic             v1, v2, v3;
    logic [1:0]       op1, op2, op3;
    logic [WIDTH-1:0] a1, b1;
    logic [PW-1:0]    p2, p_nx;
    logic [RW-1:0]    r3, r3_nx;

    logic [PW+MW-1:0] pm;
    logic [MW-1:0]    qh;
    logic [RW-1:0]    r4a, r4b;
    logic [WIDTH-1:0] r4, mac4, res4;
    logic [WIDTH:0]   sum4;

    assign in_ready = !(out_valid && !out_ready);
    assign adv      = in_ready;

    always_comb begin
        p_nx = '0;
        case (op1)
            OP_ADD:  p_nx = PW'(a1) + PW'(b1);
            OP_SUB:  p_nx = PW'(a1) + PW'(QW) - PW'(b1);
            default: p_nx = PW'(a1) * PW'(b1);
        endcase
    end

    // Barrett estimate leaves r' in [0, 3Q); two conditional subtracts finish it.
    assign pm    = (PW + MW)'(p2) * (PW + MW)'(M);
    assign qh    = MW'(pm >> K);
    assign r3_nx = RW'(p2 - PW'(qh) * PW'(QW));

    assign r4a  = (r3 >= QR) ? r3 - QR : r3;
    assign r4b  = (r4a >= QR) ? r4a - QR : r4a;
    assign r4   = WIDTH'(r4b);
    assign sum4 = {1'b0, r4} + {1'b0, acc};
    assign mac4 = (sum4 >= QS) ? WIDTH'(sum4 - QS) : WIDTH'(sum4);
    assign res4 = (op3 == OP_MAC) ? mac4 : r4;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            acc       <= '0;
            range_err <= 1'b0;
            op_cnt    <= '0;
        end else begin
            if (adv) begin
                v1        <= in_valid;
                a1        <= a;
                b1        <= b;
                op1       <= op;
                v2        <= v1;
                op2       <= op1;
                p2        <= p_nx;
                v3        <= v2;
                op3       <= op2;
                r3        <= r3_nx;
                out_valid <= v3;
                if (v3)
                    result <= res4;
            end
            if (in_valid && adv && (a >= QW || b >= QW))
                range_err <= 1'b1;
            // A clear beats a MAC retiring on the same edge.
            if (acc_clr)
                acc <= '0;
            else if (adv && v3 && op3 == OP_MAC)
                acc <= mac4;
            if (out_valid && out_ready)
                op_cnt <= op_cnt + 1'b1;
        end
    end

endmodule

// File: doc/mod_arith_pipe.md
Name: mod_arith_pipe

Overview:
- Parametrised, pipelined modular arithmetic unit over Z_Q for the lattice/NTT datapath.
- Generalises the fixed-width single modular multiplier: configurable WIDTH and modulus Q, per-operation mode (mul/add/sub/MAC), valid/ready handshake with backpressure, internal accumulator and an operation counter.
- Sits between coefficient memory and the NTT butterfly/pointwise-multiply controllers.

Parameters:
- WIDTH, 13, operand/result width in bits; Q must be < 2^WIDTH.
- Q, 7681, modulus; odd, with Q > 2^(WIDTH-1).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- op  in  2  mode: 00 mul, 01 add, 10 sub, 11 MAC.
- a  in  WIDTH  operand A, canonical in [0, Q-1].
- b  in  WIDTH  operand B, canonical in [0, Q-1].
- acc_clr  in  1  clears the accumulator; single-cycle pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  canonical result in [0, Q-1].
- acc  out  WIDTH  current accumulator value.
- range_err  out  1  sticky flag: an accepted operand was >= Q.
- op_cnt  out  CNT_W  count of results handed off (out_valid && out_ready).

Behaviour:
- Reset: out_valid, result, acc, range_err, op_cnt and all internal stage valids go to 0. in_ready goes to 1 in the cycle after rst is deasserted. Reset mid-operation discards every in-flight beat.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready). It is combinational from out_ready.
  - Stall: when out_valid && !out_ready, the whole pipeline holds. result stays stable and out_valid stays 1 until consumed.
- Latency: fixed 4 cycles from accept edge to out_valid with no stalls. Full throughput is one beat per cycle. Bubbles propagate as invalid stages.
- Stage 1 (S1): register a, b, op and valid. If a >= Q or b >= Q, set range_err (it stays set until rst). The beat still flows, but its result is unspecified.
- Stage 2 (S2):
  - mul/MAC: p = a*b, 2*WIDTH bits.
  - add: p = a+b.
  - sub: p = a-b+Q.
- Stage 3 (S3): Barrett estimate.
  - K = 2*WIDTH, M = floor(2^K / Q), a localparam.
  - qh = (p*M) >> K.
  - r' = p - qh*Q, which is < 3Q.
- Stage 4 (S4):
  - r = r' minus Q, repeated up to two times while r' >= Q.
  - mul/add/sub: result = r.
  - MAC: result = (r + acc) mod Q via a single conditional subtract, and acc takes the same value on the same edge.
- MAC ordering:
  - The accumulator add happens only in S4, so back-to-back MACs are correctly chained with no hazard.
  - A stalled MAC updates acc once, on the edge its result enters the output register.
- acc_clr:
  - It sets acc to 0 at the next edge.
  - If it coincides with a MAC completing in S4, acc_clr wins: acc = 0 and that MAC's result uses the old acc.
  - Non-MAC ops never touch acc.
- op_cnt increments on each consume and wraps modulo 2^CNT_W.
- No combinational path from a, b or in_valid to any output.

Test Plan:
- Mul, Q=7681: a=4592, b=6651, op=00, out_ready=1 -> result=1736, 4 cycles after accept. Next beat a=5623, b=7265 -> 3537.
- Add/sub/boundary: op=01 with 4592,6651 -> 3562. op=10 with 4592,6651 -> 5622. op=00 with 7680,7680 -> 1. op=01 with 7680,7680 -> 7679. op=10 with 0,0 -> 0.
- MAC chain: acc_clr, then back-to-back MACs (4592,6651), (5623,7265) -> results 1736, then 5273; acc=5273. acc_clr coincident with a third MAC -> acc=0.
- Backpressure: stream 8 random beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, result held stable, no beat lost or duplicated, order preserved, op_cnt=8. Check results against a reference model.
- Range/reset: a=7681 accepted -> range_err=1 and remains set. Assert rst with 3 beats in flight -> out_valid=0, acc=0, op_cnt=0, range_err=0 next cycle, and no stale results after release.
- Parametrisation: WIDTH=12, Q=3329, 10k random canonical beats across all ops -> results match the reference model; op_cnt wraps with CNT_W=4.
